// File: rtl/sweep_counter_pkg.sv
// -----------------------------------------------------------------------------
// sweep_counter_pkg
// Shared encodings for the sweep_counter slice: controller states, sweep mode
// selectors and the bounce-direction phase.
// -----------------------------------------------------------------------------
package sweep_counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MODE_UP     = 0;
  localparam int MODE_DOWN   = 1;
  localparam int MODE_BOUNCE = 2;

  // Direction of travel within a bounce sweep.
  typedef enum logic {
    PHASE_FWD = 1'b0,
    PHASE_REV = 1'b1
  } phase_t;

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides the clock into one-cycle step ticks, one every PRESCALE enabled
// cycles. The first tick arrives PRESCALE cycles after a clear.
//
// Ports:
//   clock   in   system clock, rising edge
//   reset   in   asynchronous active-high reset
//   clear   in   synchronous restart of the division count
//   enable  in   count only while high
//   tick    out  high in the cycle the count reaches PRESCALE-1
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  // Keep at least one bit so PRESCALE=1 still yields a legal vector.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] div_count;

  assign tick = enable && (div_count == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_count <= '0;
    end else if (clear) begin
      div_count <= '0;
    end else if (enable) begin
      div_count <= tick ? '0 : div_count + CW'(1);
    end
  end

endmodule

// File: rtl/sweep_counter.sv
// -----------------------------------------------------------------------------
// sweep_counter
// Steps a WIDTH-bit count from START toward TARGET (up, down or bounce) at a
// rate set by PRESCALE, then emits a one-cycle `next` pulse so stages can be
// chained next -> go. Supports abort, busy and re-arm protection: a go held
// high across completion does not restart the block until go drops.
//
// Optional feature: define SWEEP_COUNTER_LOOP_EN to make the counter free-run
// (DONE returns straight to RUN) until abort or reset.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   go         in   start request, level-sampled
//   abort      in   synchronous cancel of a run in progress
//   busy       out  high while in RUN
//   next       out  one-cycle completion pulse
//   count_out  out  current count (0 when not running)
// -----------------------------------------------------------------------------
module sweep_counter #(
  parameter int WIDTH    = 5,
  parameter int MODE     = 0,
  parameter int START    = 0,
  parameter int TARGET   = 31,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             abort,
  output logic             busy,
  output logic             next,
  output logic [WIDTH-1:0] count_out
);

  import sweep_counter_pkg::*;

  localparam logic [WIDTH-1:0] START_V  = WIDTH'(START);
  localparam logic [WIDTH-1:0] TARGET_V = WIDTH'(TARGET);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state, state_n;
  phase_t           phase, phase_n;
  logic [WIDTH-1:0] count_n;
  logic             armed, armed_n;
  logic             tick;
  logic             clear;
  logic             terminal;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .enable (state == RUN),
    .tick   (tick)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    phase_n  = phase;
    count_n  = count_out;
    armed_n  = armed;
    clear    = 1'b0;
    terminal = 1'b0;

    unique case (state)
      IDLE: begin
        // abort outranks go, so both high together keeps us idle.
        if (go && armed && !abort) begin
          state_n = RUN;
          count_n = START_V;
          phase_n = PHASE_FWD;
          clear   = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          state_n = IDLE;
          count_n = '0;
          clear   = 1'b1;
        end else if (tick) begin
          if (MODE == MODE_DOWN) begin
            if (count_out == TARGET_V) terminal = 1'b1;
            else                       count_n  = count_out - ONE;
          end else if (MODE == MODE_BOUNCE) begin
            if (START_V == TARGET_V) begin
              terminal = 1'b1;
            end else if (phase == PHASE_FWD) begin
              // Reaching TARGET spends one tick turning around in place.
              if (count_out == TARGET_V) phase_n = PHASE_REV;
              else                       count_n = count_out + ONE;
            end else begin
              if (count_out == START_V) terminal = 1'b1;
              else                      count_n  = count_out - ONE;
            end
          end else begin
            if (count_out == TARGET_V) terminal = 1'b1;
            else                       count_n  = count_out + ONE;
          end

          if (terminal) begin
            state_n = DONE;
            count_n = '0;
          end
        end
      end

      DONE: begin
`ifdef SWEEP_COUNTER_LOOP_EN
        // Free-running: reload immediately; abort is the only way out.
        if (abort) begin
          state_n = IDLE;
        end else begin
          state_n = RUN;
          count_n = START_V;
          phase_n = PHASE_FWD;
          clear   = 1'b1;
        end
`else
        state_n = IDLE;
`endif
      end

      default: state_n = IDLE;
    endcase

    // Any cycle with go low re-arms; completion with go still high disarms so
    // a held go cannot retrigger the block.
    if (!go)           armed_n = 1'b1;
    else if (terminal) armed_n = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= PHASE_FWD;
      count_out <= '0;
      armed     <= 1'b1;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      count_out <= count_n;
      armed     <= armed_n;
    end
  end

  assign busy = (state == RUN);
  assign next = (state == DONE);

endmodule

// File: tb/tb_sweep_counter.sv
// -----------------------------------------------------------------------------
// tb_sweep_counter
// Scoreboard bench for sweep_counter. Four instances cover the default up
// sweep, a prescaled bounce, a wrapping down sweep and a short up sweep (used
// for the loop feature when SWEEP_COUNTER_LOOP_EN is defined). Stimulus pushes
// the expected per-cycle {busy, next, count} trace into a queue per instance;
// a monitor on the falling edge pops one entry per cycle and compares, and
// expects the idle pattern whenever the queue is empty.
// -----------------------------------------------------------------------------
module tb_sweep_counter;

  typedef struct packed {
    logic       busy;
    logic       next;
    logic [4:0] count;
  } obs_t;

  localparam obs_t IDLE_OBS = '0;

  logic       clock;
  logic       reset;
  logic [3:0] go;
  logic [3:0] abort;
  logic [3:0] busy;
  logic [3:0] next;
  logic [4:0] cnt0, cnt1, cnt2, cnt3;

  obs_t q0[$], q1[$], q2[$], q3[$];

  int checks   = 0;
  int failures = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  sweep_counter u_def (
    .clock (clock), .reset (reset), .go (go[0]), .abort (abort[0]),
    .busy (busy[0]), .next (next[0]), .count_out (cnt0)
  );

  sweep_counter #(.MODE(2), .START(3), .TARGET(6), .PRESCALE(2)) u_bnc (
    .clock (clock), .reset (reset), .go (go[1]), .abort (abort[1]),
    .busy (busy[1]), .next (next[1]), .count_out (cnt1)
  );

  sweep_counter #(.MODE(1), .START(2), .TARGET(30)) u_dn (
    .clock (clock), .reset (reset), .go (go[2]), .abort (abort[2]),
    .busy (busy[2]), .next (next[2]), .count_out (cnt2)
  );

  sweep_counter #(.TARGET(3)) u_lp (
    .clock (clock), .reset (reset), .go (go[3]), .abort (abort[3]),
    .busy (busy[3]), .next (next[3]), .count_out (cnt3)
  );

  task automatic check(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got busy=%0b next=%0b count=%0d, expected busy=%0b next=%0b count=%0d",
               name, $time, act.busy, act.next, act.count, exp.busy, exp.next, exp.count);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int d, input logic b, input logic n, input logic [4:0] c);
    obs_t o;
    o = {b, n, c};
    case (d)
      0:       q0.push_back(o);
      1:       q1.push_back(o);
      2:       q2.push_back(o);
      default: q3.push_back(o);
    endcase
  endtask

  task automatic push_idle(input int d);         push(d, 1'b0, 1'b0, 5'd0); endtask
  task automatic push_run(input int d, input int c); push(d, 1'b1, 1'b0, 5'(c)); endtask
  task automatic push_done(input int d);         push(d, 1'b0, 1'b1, 5'd0); endtask

  // Defaults: 0..31 one cycle each, then the DONE pulse.
  task automatic push_default_trace(input int d);
    push_idle(d);
    for (int v = 0; v <= 31; v++) push_run(d, v);
    push_done(d);
  endtask

  // Bounce 3->6->3, two cycles per tick; TARGET holds two ticks while turning.
  task automatic push_bounce_trace();
    int seq[7] = '{3, 4, 5, 6, 5, 4, 3};
    push_idle(1);
    foreach (seq[i]) begin
      for (int k = 0; k < ((seq[i] == 6) ? 4 : 2); k++) push_run(1, seq[i]);
    end
    push_done(1);
  endtask

  // Down 2 -> 30 through the wrap: 2,1,0,31,30.
  task automatic push_down_trace();
    int seq[5] = '{2, 1, 0, 31, 30};
    push_idle(2);
    foreach (seq[i]) push_run(2, seq[i]);
    push_done(2);
  endtask

  task automatic push_short_pass();
    for (int v = 0; v <= 3; v++) push_run(3, v);
    push_done(3);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: one comparison per instance per cycle, away from the rising edge.
  always @(negedge clock) begin
    obs_t e;
    e = (q0.size() != 0) ? q0.pop_front() : IDLE_OBS;
    check("def", {busy[0], next[0], cnt0}, e);
    e = (q1.size() != 0) ? q1.pop_front() : IDLE_OBS;
    check("bnc", {busy[1], next[1], cnt1}, e);
    e = (q2.size() != 0) ? q2.pop_front() : IDLE_OBS;
    check("dn", {busy[2], next[2], cnt2}, e);
    e = (q3.size() != 0) ? q3.pop_front() : IDLE_OBS;
    check("lp", {busy[3], next[3], cnt3}, e);
  end

  initial begin
    go    = '0;
    abort = '0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);

`ifndef SWEEP_COUNTER_LOOP_EN
    // All four instances start together from a one-cycle go pulse.
    go = 4'b1111;
    push_default_trace(0);
    push_bounce_trace();
    push_down_trace();
    push_idle(3);
    push_short_pass();
    step(1);
    go = '0;
    step(40);

    // go held through completion: one run only, then a drop re-arms.
    go[0] = 1'b1;
    push_default_trace(0);
    step(40);
    go[0] = 1'b0;
    step(1);
    go[0] = 1'b1;
    push_default_trace(0);
    step(40);
    go[0] = 1'b0;
    step(3);

    // Abort while the count shows 10: idle next cycle, no pulse.
    go[0] = 1'b1;
    push_idle(0);
    for (int v = 0; v <= 10; v++) push_run(0, v);
    step(1);
    go[0] = 1'b0;
    step(10);
    abort[0] = 1'b1;
    step(1);
    abort[0] = 1'b0;
    step(3);

    // go and abort together in IDLE: nothing starts.
    go[0]    = 1'b1;
    abort[0] = 1'b1;
    step(1);
    go[0]    = 1'b0;
    abort[0] = 1'b0;
    step(3);

    // Reset in the middle of a run clears outputs without waiting for a clock.
    go[0] = 1'b1;
    push_idle(0);
    for (int v = 0; v <= 4; v++) push_run(0, v);
    step(1);
    go[0] = 1'b0;
    step(5);
    check("pre_reset", {busy[0], next[0], cnt0}, {1'b1, 1'b0, 5'd5});
    #1 reset = 1'b1;
    #1 check("async_reset", {busy[0], next[0], cnt0}, IDLE_OBS);
    q0.delete();
    step(1);
    reset = 1'b0;
    step(2);

    // Block is armed again after reset.
    go[2] = 1'b1;
    push_down_trace();
    step(1);
    go[2] = 1'b0;
    step(10);
`else
    // Free-running: next every 5 cycles with go low, abort ends it mid-pass.
    go[3] = 1'b1;
    push_idle(3);
    repeat (3) push_short_pass();
    push_run(3, 0);
    push_run(3, 1);
    step(1);
    go[3] = 1'b0;
    step(16);
    abort[3] = 1'b1;
    step(1);
    abort[3] = 1'b0;
    step(10);
`endif

    check_int("q0_drained", q0.size(), 0);
    check_int("q1_drained", q1.size(), 0);
    check_int("q2_drained", q2.size(), 0);
    check_int("q3_drained", q3.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
